axi_ctrl_regfile: RTL
=====================

AXI_CTRL_REGFILE -- requirements
Module: axi_ctrl_regfile

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h4000_0000, base byte address of the register window.
REQ-002 SHALL provide parameter NUM_IRQ, default 4, legal 1..32, number of interrupt request/acknowledge channels.
REQ-003 SHALL provide parameter ACK_TIMEOUT, default 0, max WAIT_REQ cycles (0 = wait forever).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 mem_start_ready  out  1  level, mem_start valid and run requested.
REQ-007 mem_start  out  32  program start address.
REQ-008 interrupt_req  in  NUM_IRQ  per-channel interrupt request levels.
REQ-009 interrupt_ack  out  NUM_IRQ  per-channel one-cycle acknowledge pulses.
REQ-010 awid  in  12  write address ID.
REQ-011 awvalid  in  1 / awready  out  1  AW handshake pair.
REQ-012 awaddr  in  32 / awlen  in  8 / awsize  in  3  write address, burst length, beat size (awburst ignored, not a port).
REQ-013 wid  in  12 / wvalid  in  1 / wready  out  1  W channel ID and handshake.
REQ-014 wdata  in  32 / wstrb  in  4 / wlast  in  1  write beat payload.
REQ-015 bid  out  12 / bresp  out  2 / bvalid  out  1 / bready  in  1  write response channel, AXI3.

Function
REQ-016 Register map: BASE+0 MEM_START, BASE+4 IRQ_ACK (wdata[NUM_IRQ-1:0] = channel mask), BASE+8 RUN_CLEAR (data ignored); any other address is an error.
REQ-017 FSM states IDLE, WDATA, WAIT_REQ, RESP; exactly one transaction outstanding.
REQ-018 awready SHALL be 1 only in IDLE; wready 1 only in WDATA; bvalid 1 only in RESP.
REQ-019 IDLE: on awvalid&&awready latch bid<=awid, decode address, set err if awlen!=0, awsize!=3'b010 or address unmapped; go WDATA unconditionally.
REQ-020 W beats offered before the AW handshake SHALL stall (wready=0), never be dropped or reordered.
REQ-021 WDATA: on wvalid&&wready, beat illegal if wstrb!=4'hF, wlast==0, or wid!=bid; err or illegal beat -> RESP with bresp=2'b10, no register side effect.
REQ-022 Legal MEM_START write: mem_start<=wdata and mem_start_ready<=1 on the handshake edge; -> RESP, bresp=2'b00.
REQ-023 Legal RUN_CLEAR write: mem_start_ready<=0, mem_start unchanged; -> RESP, bresp=2'b00.
REQ-024 Legal IRQ_ACK write: latch mask; interrupt_ack<=mask for exactly one cycle; mask==0 -> RESP OKAY, else -> WAIT_REQ.
REQ-025 WAIT_REQ: from the cycle after the ack pulse, when (interrupt_req & mask)==0 -> RESP, bresp=2'b00; unmasked channels ignored.
REQ-026 WAIT_REQ with ACK_TIMEOUT!=0: cycle counter (width $clog2(ACK_TIMEOUT+1)) cleared on entry; on reaching ACK_TIMEOUT with masked requests still high -> RESP, bresp=2'b10; release on that same cycle wins (OKAY).
REQ-027 RESP: bid and bresp stable while bvalid=1; on bvalid&&bready -> IDLE, awready=1 next cycle, err cleared.
REQ-028 interrupt_ack SHALL be 0 in every cycle other than the single pulse cycle of REQ-024.
REQ-029 Write-to-response latency: MEM_START/RUN_CLEAR/error: bvalid one cycle after the W handshake; IRQ_ACK: one cycle after release detected.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, awready=1, wready=0, bvalid=0, bresp=0, bid=0, mem_start=0, mem_start_ready=0, interrupt_ack=0, mask=0, counter=0.
REQ-031 Reset mid-transaction SHALL abandon it silently: no B response, no register update, no ack pulse after the reset edge.

Verification
REQ-032 Write 32'h8000_1000 to BASE+0, awid=12'h05 -> mem_start=32'h8000_1000, mem_start_ready=1, bid=12'h05, bresp=0.
REQ-033 Write mask 4'b0101 to BASE+4, hold interrupt_req=4'b0111 for 10 cycles then drop bits 0 and 2 only -> one-cycle ack=4'b0101, bvalid one cycle after drop, bresp=0 though bit 1 stays high.
REQ-034 ACK_TIMEOUT=8, write mask 4'b0001 with interrupt_req[0] stuck high -> bresp=2'b10 after 8 WAIT_REQ cycles, FSM returns to IDLE.
REQ-035 Write to BASE+12, then awlen=1, then wstrb=4'h3, then wid!=awid -> each bresp=2'b10, mem_start/mem_start_ready unchanged.
REQ-036 wvalid asserted 3 cycles before awvalid, then bready held low 5 cycles -> wready=0 until after AW handshake, bvalid/bresp/bid held stable, next awready only after bready.
REQ-037 Assert rst during WAIT_REQ -> all outputs at reset values next cycle, no bvalid, subsequent MEM_START write completes normally.

Source files
------------

// File: rtl/axi_ctrl_regfile.sv
// AXI3 write-only control register window: program start address, run clear and
// interrupt acknowledge that waits for the acknowledged requests to drop.
module axi_ctrl_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          NUM_IRQ     = 4,
  parameter int          ACK_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_start_ready,
  output logic [31:0]        mem_start,
  input  logic [NUM_IRQ-1:0] interrupt_req,
  output logic [NUM_IRQ-1:0] interrupt_ack,
  input  logic [11:0]        awid,
  input  logic               awvalid,
  output logic               awready,
  input  logic [31:0]        awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [11:0]        wid,
  input  logic               wvalid,
  output logic               wready,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  output logic [11:0]        bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready
);

  localparam int             CNT_W       = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(ACK_TIMEOUT);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WAIT_REQ = 2'd2, RESP = 2'd3} state_t;
  typedef enum logic [1:0] {SEL_MEM = 2'd0, SEL_ACK = 2'd1, SEL_CLR = 2'd2, SEL_NONE = 2'd3} sel_t;

  function automatic sel_t decode(input logic [31:0] addr);
    if (addr == BASE_ADDR) begin
      return SEL_MEM;
    end else if (addr == BASE_ADDR + 32'd4) begin
      return SEL_ACK;
    end else if (addr == BASE_ADDR + 32'd8) begin
      return SEL_CLR;
    end else begin
      return SEL_NONE;
    end
  endfunction

  state_t             state, state_n;
  sel_t               sel, sel_n, aw_sel;
  logic               err, err_n;
  logic [11:0]        bid_n;
  logic [1:0]         bresp_n;
  logic [31:0]        mem_start_n;
  logic               mem_start_ready_n;
  logic [NUM_IRQ-1:0] ack_n, mask, mask_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W:0]     cnt_inc;
  logic               aw_hs, w_hs, b_hs, beat_bad, masked_busy, ack_pulse, timed_out;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign b_hs        = bvalid && bready;
  assign aw_sel      = decode(awaddr);
  assign beat_bad    = (wstrb != 4'hF) || !wlast || (wid != bid);
  assign masked_busy = |(interrupt_req & mask);
  // The pulse cycle itself is not a release candidate; release is judged from the next cycle.
  assign ack_pulse   = |interrupt_ack;
  assign cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign timed_out   = (TIMEOUT_LIM != '0) && (cnt_inc >= TIMEOUT_LIM);

  // Next-state and next-register computation for the single outstanding transaction.
  always_comb begin
    state_n           = state;
    sel_n             = sel;
    err_n             = err;
    bid_n             = bid;
    bresp_n           = bresp;
    mem_start_n       = mem_start;
    mem_start_ready_n = mem_start_ready;
    ack_n             = '0;
    mask_n            = mask;
    cnt_n             = cnt;
    case (state)
      IDLE: begin
        if (aw_hs) begin
          bid_n   = awid;
          sel_n   = aw_sel;
          err_n   = (awlen != 8'd0) || (awsize != 3'b010) || (aw_sel == SEL_NONE);
          state_n = WDATA;
        end else begin
          state_n = IDLE;
        end
      end
      WDATA: begin
        if (w_hs) begin
          state_n = RESP;
          bresp_n = RESP_OKAY;
          if (err || beat_bad) begin
            bresp_n = RESP_SLVERR;
          end else begin
            case (sel)
              SEL_MEM: begin
                mem_start_n       = wdata;
                mem_start_ready_n = 1'b1;
              end
              SEL_CLR: begin
                mem_start_ready_n = 1'b0;
              end
              SEL_ACK: begin
                mask_n = wdata[NUM_IRQ-1:0];
                ack_n  = wdata[NUM_IRQ-1:0];
                cnt_n  = '0;
                if (|wdata[NUM_IRQ-1:0]) begin
                  state_n = WAIT_REQ;
                end else begin
                  state_n = RESP;
                end
              end
              default: begin
                bresp_n = RESP_SLVERR;
              end
            endcase
          end
        end else begin
          state_n = WDATA;
        end
      end
      WAIT_REQ: begin
        if (ack_pulse) begin
          cnt_n = cnt_inc[CNT_W-1:0];
        end else if (!masked_busy) begin
          bresp_n = RESP_OKAY;
          state_n = RESP;
        end else if (timed_out) begin
          bresp_n = RESP_SLVERR;
          state_n = RESP;
        end else begin
          cnt_n = cnt_inc[CNT_W-1:0];
        end
      end
      RESP: begin
        if (b_hs) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, register and handshake-output flops; ready/valid follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sel             <= SEL_NONE;
      err             <= 1'b0;
      bid             <= 12'h000;
      bresp           <= 2'b00;
      mem_start       <= 32'h0000_0000;
      mem_start_ready <= 1'b0;
      interrupt_ack   <= '0;
      mask            <= '0;
      cnt             <= '0;
      awready         <= 1'b1;
      wready          <= 1'b0;
      bvalid          <= 1'b0;
    end else begin
      state           <= state_n;
      sel             <= sel_n;
      err             <= err_n;
      bid             <= bid_n;
      bresp           <= bresp_n;
      mem_start       <= mem_start_n;
      mem_start_ready <= mem_start_ready_n;
      interrupt_ack   <= ack_n;
      mask            <= mask_n;
      cnt             <= cnt_n;
      awready         <= (state_n == IDLE);
      wready          <= (state_n == WDATA);
      bvalid          <= (state_n == RESP);
    end
  end

endmodule
